// File: rtl/noc_pkg.sv
// Shared NoC definitions: width derivation helpers, the flit layout for the
// default local-port configuration, and the injector FSM state encoding.
package noc_pkg;

    // Default local-port configuration (128-bit data, 4-bit tdest, 2-bit tid, SF=1).
    localparam int unsigned DEF_FLIT_WIDTH = 128;
    localparam int unsigned DEF_DEST_WIDTH = 6;

    function automatic int unsigned flit_width(input int unsigned tdata_width,
                                               input int unsigned sf);
        return tdata_width / sf;
    endfunction

    function automatic int unsigned dest_width(input int unsigned tdest_width,
                                               input int unsigned tid_width);
        return tdest_width + tid_width;
    endfunction

    // Counter must hold every value from 0 up to and including depth.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [DEF_FLIT_WIDTH-1:0] data;
        logic [DEF_DEST_WIDTH-1:0] dest;
        logic                      is_tail;
    } flit_t;

    typedef enum logic {
        StIdle,
        StSend
    } inj_state_e;

endpackage

// File: rtl/axis_flit_injector_if.sv
// Bundle of the AXIS input, flit output, credit return and status signals of
// the flit injector.
//   master: user/router side (drives AXIS beats and credit returns)
//   slave : injector side (drives tready, flits and credit status)
interface axis_flit_injector_if #(
    parameter int unsigned TDATA_WIDTH          = 128,
    parameter int unsigned TDEST_WIDTH          = 4,
    parameter int unsigned TID_WIDTH            = 2,
    parameter int unsigned SERIALIZATION_FACTOR = 1,
    parameter int unsigned FLIT_BUFFER_DEPTH    = 2
) ();
    localparam int unsigned FLIT_WIDTH = noc_pkg::flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR);
    localparam int unsigned DEST_WIDTH = noc_pkg::dest_width(TDEST_WIDTH, TID_WIDTH);
    localparam int unsigned CNT_WIDTH  = noc_pkg::credit_w(FLIT_BUFFER_DEPTH);

    logic                   axis_in_tvalid;
    logic                   axis_in_tready;
    logic [TDATA_WIDTH-1:0] axis_in_tdata;
    logic                   axis_in_tlast;
    logic [TID_WIDTH-1:0]   axis_in_tid;
    logic [TDEST_WIDTH-1:0] axis_in_tdest;
    logic [FLIT_WIDTH-1:0]  data_out;
    logic [DEST_WIDTH-1:0]  dest_out;
    logic                   is_tail_out;
    logic                   send_out;
    logic                   credit_in;
    logic [CNT_WIDTH-1:0]   credit_count;
    logic                   err_credit_overflow;

    modport master (
        output axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest,
        output credit_in,
        input  axis_in_tready, data_out, dest_out, is_tail_out, send_out,
        input  credit_count, err_credit_overflow
    );

    modport slave (
        input  axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest,
        input  credit_in,
        output axis_in_tready, data_out, dest_out, is_tail_out, send_out,
        output credit_count, err_credit_overflow
    );

endinterface

// File: rtl/noc_credit_counter.sv
// Credit counter for a downstream buffer of DEPTH entries.
//   clk_noc, rst : clock, synchronous active-high reset (count -> DEPTH)
//   consume      : one flit sent this cycle (-1)
//   credit_in    : one credit returned this cycle (+1)
//   count        : credits currently available
//   avail        : count != 0
//   overflow     : sticky, set by a return while already at DEPTH
module noc_credit_counter
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_noc,
    input  logic                       rst,
    input  logic                       consume,
    input  logic                       credit_in,
    output logic [credit_w(DEPTH)-1:0] count,
    output logic                       avail,
    output logic                       overflow
);
    localparam int unsigned CW = credit_w(DEPTH);

    logic [CW-1:0] count_q;
    logic          overflow_q;

    always_ff @(posedge clk_noc) begin
        if (rst) begin
            count_q    <= CW'(DEPTH);
            overflow_q <= 1'b0;
        end else if (consume && !credit_in) begin
            count_q <= count_q - CW'(1);
        end else if (credit_in && !consume) begin
            // A return with the buffer already fully credited is a protocol error;
            // hold the count rather than wrapping.
            if (count_q == CW'(DEPTH)) begin
                overflow_q <= 1'b1;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign count    = count_q;
    assign avail    = (count_q != '0);
    assign overflow = overflow_q;

endmodule

// File: rtl/axis_flit_injector.sv
// Credit-aware AXI-Stream to NoC flit injector. Each accepted beat is split
// into SERIALIZATION_FACTOR flits (LSB slice first) tagged with {tid, tdest};
// the last flit of a tlast beat is the tail. Flits leave only while the
// downstream buffer has credit.
//   clk_noc : clock
//   rst     : synchronous active-high reset
//   bus     : AXIS input, flit output, credit return and status (slave side)
module axis_flit_injector
    import noc_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH          = 128,
    parameter int unsigned TDEST_WIDTH          = 4,
    parameter int unsigned TID_WIDTH            = 2,
    parameter int unsigned SERIALIZATION_FACTOR = 1,
    parameter int unsigned FLIT_BUFFER_DEPTH    = 2
) (
    input logic                 clk_noc,
    input logic                 rst,
    axis_flit_injector_if.slave bus
);
    localparam int unsigned SF         = SERIALIZATION_FACTOR;
    localparam int unsigned FLIT_WIDTH = flit_width(TDATA_WIDTH, SF);
    localparam int unsigned DEST_WIDTH = dest_width(TDEST_WIDTH, TID_WIDTH);
    localparam int unsigned IDX_W      = (SF > 1) ? $clog2(SF) : 1;

    if (!(SF == 1 || SF == 2 || SF == 4 || SF == 8)) begin : g_bad_sf
        $error("SERIALIZATION_FACTOR must be 1, 2, 4 or 8");
    end
    if ((TDATA_WIDTH % SF) != 0) begin : g_bad_div
        $error("SERIALIZATION_FACTOR must divide TDATA_WIDTH");
    end
    if (FLIT_BUFFER_DEPTH < 1 || FLIT_BUFFER_DEPTH > 64) begin : g_bad_depth
        $error("FLIT_BUFFER_DEPTH must be in 1..64");
    end

    inj_state_e                    state_q;
    logic [SF-1:0][FLIT_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0]         dest_q;
    logic                          last_q;
    logic [IDX_W-1:0]              idx_q;

    logic                  avail;
    logic                  send;
    logic                  last_slice;
    logic                  beat_done;
    logic                  accept;
    logic [FLIT_WIDTH-1:0] flit_data;

    // With SF=1 idx_q never leaves 0, so every flit is the last slice.
    assign last_slice = (idx_q == IDX_W'(SF - 1));
    assign send       = (state_q == StSend) && avail;
    assign beat_done  = send && last_slice;
    // Depends only on registered state: no path from credit_in or tvalid.
    assign bus.axis_in_tready = (state_q == StIdle) || beat_done;
    assign accept             = bus.axis_in_tvalid && bus.axis_in_tready;

    always_ff @(posedge clk_noc) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            dest_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            state_q <= StSend;
            data_q  <= bus.axis_in_tdata;
            dest_q  <= {bus.axis_in_tid, bus.axis_in_tdest};
            last_q  <= bus.axis_in_tlast;
            idx_q   <= '0;
        end else if (beat_done) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else if (send) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        flit_data = data_q[0];
        for (int i = 1; i < SF; i++) begin
            if (idx_q == IDX_W'(i)) begin
                flit_data = data_q[i];
            end
        end
    end

    assign bus.data_out    = flit_data;
    assign bus.dest_out    = dest_q;
    assign bus.is_tail_out = last_q && last_slice;
    assign bus.send_out    = send;

    noc_credit_counter #(
        .DEPTH(FLIT_BUFFER_DEPTH)
    ) u_credit (
        .clk_noc  (clk_noc),
        .rst      (rst),
        .consume  (send),
        .credit_in(bus.credit_in),
        .count    (bus.credit_count),
        .avail    (avail),
        .overflow (bus.err_credit_overflow)
    );

endmodule

// File: tb/tb_axis_flit_injector.sv
// Directed bench: u_dut1 (SF=1, DEPTH=2) and u_dut4 (SF=4, DEPTH=8).
// Each cycle: wait for posedge, #1, check outputs, then drive inputs.
module tb_axis_flit_injector;

    logic clk_noc = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk_noc = ~clk_noc;

    axis_flit_injector_if #(
        .TDATA_WIDTH(128), .TDEST_WIDTH(4), .TID_WIDTH(2),
        .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(2)
    ) bus1 ();

    axis_flit_injector_if #(
        .TDATA_WIDTH(128), .TDEST_WIDTH(4), .TID_WIDTH(2),
        .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(8)
    ) bus4 ();

    axis_flit_injector #(
        .TDATA_WIDTH(128), .TDEST_WIDTH(4), .TID_WIDTH(2),
        .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(2)
    ) u_dut1 (
        .clk_noc(clk_noc),
        .rst    (rst),
        .bus    (bus1)
    );

    axis_flit_injector #(
        .TDATA_WIDTH(128), .TDEST_WIDTH(4), .TID_WIDTH(2),
        .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(8)
    ) u_dut4 (
        .clk_noc(clk_noc),
        .rst    (rst),
        .bus    (bus4)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [127:0] d, input logic l,
                          input logic [1:0] id, input logic [3:0] de);
        bus1.axis_in_tvalid = v;
        bus1.axis_in_tdata  = d;
        bus1.axis_in_tlast  = l;
        bus1.axis_in_tid    = id;
        bus1.axis_in_tdest  = de;
    endtask

    // Check the SF=1 flit outputs for a cycle where a flit is expected.
    task automatic check_flit1(input string tag, input logic [127:0] d, input logic [5:0] de,
                               input logic tail);
        check({tag, "_send"}, 128'(bus1.send_out), 128'd1);
        if (bus1.send_out) begin
            check({tag, "_data"}, bus1.data_out, d);
            check({tag, "_dest"}, 128'(bus1.dest_out), 128'(de));
            check({tag, "_tail"}, 128'(bus1.is_tail_out), 128'(tail));
        end
    endtask

    task automatic check_flit4(input string tag, input logic [31:0] d, input logic tail,
                               input logic rdy);
        check({tag, "_send"}, 128'(bus4.send_out), 128'd1);
        if (bus4.send_out) begin
            check({tag, "_data"}, 128'(bus4.data_out), 128'(d));
            check({tag, "_dest"}, 128'(bus4.dest_out), 128'h23);
            check({tag, "_tail"}, 128'(bus4.is_tail_out), 128'(tail));
        end
        check({tag, "_rdy"}, 128'(bus4.axis_in_tready), 128'(rdy));
    endtask

    initial begin
        drive1(1'b0, '0, 1'b0, 2'd0, 4'd0);
        bus1.credit_in      = 1'b0;
        bus4.axis_in_tvalid = 1'b0;
        bus4.axis_in_tdata  = '0;
        bus4.axis_in_tlast  = 1'b0;
        bus4.axis_in_tid    = '0;
        bus4.axis_in_tdest  = '0;
        bus4.credit_in      = 1'b0;

        // Reset held for two cycles.
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check("rst_rdy", 128'(bus1.axis_in_tready), 128'd1);
        check("rst_send", 128'(bus1.send_out), 128'd0);
        check("rst_cnt", 128'(bus1.credit_count), 128'd2);
        check("rst_err", 128'(bus1.err_credit_overflow), 128'd0);
        check("rst_data", bus1.data_out, 128'd0);
        check("rst_dest", 128'(bus1.dest_out), 128'd0);
        check("rst_tail", 128'(bus1.is_tail_out), 128'd0);
        check("rst_cnt4", 128'(bus4.credit_count), 128'd8);

        // SF=1 single beat.
        drive1(1'b1, 128'hAB, 1'b1, 2'd1, 4'd5);
        next_cycle();
        drive1(1'b0, '0, 1'b0, 2'd0, 4'd0);
        check_flit1("single", 128'hAB, 6'h15, 1'b1);
        check("single_cnt_c1", 128'(bus1.credit_count), 128'd2);
        next_cycle();
        check("single_cnt_c2", 128'(bus1.credit_count), 128'd1);
        check("single_idle", 128'(bus1.send_out), 128'd0);
        bus1.credit_in = 1'b1;
        next_cycle();
        bus1.credit_in = 1'b0;
        check("single_ret", 128'(bus1.credit_count), 128'd2);

        // SF=4 serialization on the DEPTH=8 instance.
        check("ser_rdy_c0", 128'(bus4.axis_in_tready), 128'd1);
        bus4.axis_in_tvalid = 1'b1;
        bus4.axis_in_tdata  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus4.axis_in_tlast  = 1'b1;
        bus4.axis_in_tid    = 2'd2;
        bus4.axis_in_tdest  = 4'd3;
        next_cycle();
        bus4.axis_in_tvalid = 1'b0;
        check_flit4("ser1", 32'h1111_1111, 1'b0, 1'b0);
        next_cycle();
        check_flit4("ser2", 32'h2222_2222, 1'b0, 1'b0);
        next_cycle();
        check_flit4("ser3", 32'h3333_3333, 1'b0, 1'b0);
        next_cycle();
        check_flit4("ser4", 32'h4444_4444, 1'b1, 1'b1);
        next_cycle();
        check("ser_done", 128'(bus4.send_out), 128'd0);
        check("ser_cnt", 128'(bus4.credit_count), 128'd4);
        bus4.credit_in = 1'b1;
        repeat (4) next_cycle();
        bus4.credit_in = 1'b0;
        check("ser_cnt_ret", 128'(bus4.credit_count), 128'd8);

        // Credit exhaustion: 3-beat packet, DEPTH=2.
        drive1(1'b1, 128'hAA1, 1'b0, 2'd3, 4'd9);
        next_cycle();
        check("exh_rdy1", 128'(bus1.axis_in_tready), 128'd1);
        check_flit1("exh1", 128'hAA1, 6'h39, 1'b0);
        drive1(1'b1, 128'hAA2, 1'b0, 2'd3, 4'd9);
        next_cycle();
        check("exh_rdy2", 128'(bus1.axis_in_tready), 128'd1);
        check_flit1("exh2", 128'hAA2, 6'h39, 1'b0);
        drive1(1'b1, 128'hAA3, 1'b1, 2'd3, 4'd9);
        next_cycle();
        drive1(1'b0, '0, 1'b0, 2'd0, 4'd0);
        check("exh_stall_send", 128'(bus1.send_out), 128'd0);
        check("exh_stall_rdy", 128'(bus1.axis_in_tready), 128'd0);
        check("exh_stall_cnt", 128'(bus1.credit_count), 128'd0);
        next_cycle();
        check("exh_stall2_send", 128'(bus1.send_out), 128'd0);
        bus1.credit_in = 1'b1;
        next_cycle();
        bus1.credit_in = 1'b0;
        check_flit1("exh3", 128'hAA3, 6'h39, 1'b1);
        check("exh3_cnt", 128'(bus1.credit_count), 128'd1);
        next_cycle();
        check("exh_end_cnt", 128'(bus1.credit_count), 128'd0);
        check("exh_end_rdy", 128'(bus1.axis_in_tready), 128'd1);
        bus1.credit_in = 1'b1;
        repeat (2) next_cycle();
        bus1.credit_in = 1'b0;
        check("exh_ret", 128'(bus1.credit_count), 128'd2);

        // Simultaneous send and credit return at count=1.
        drive1(1'b1, 128'hB1, 1'b0, 2'd0, 4'd2);
        next_cycle();
        check_flit1("sim1", 128'hB1, 6'h02, 1'b0);
        drive1(1'b1, 128'hB2, 1'b0, 2'd0, 4'd2);
        next_cycle();
        check_flit1("sim2", 128'hB2, 6'h02, 1'b0);
        check("sim2_cnt", 128'(bus1.credit_count), 128'd1);
        bus1.credit_in = 1'b1;
        drive1(1'b1, 128'hB3, 1'b1, 2'd0, 4'd2);
        next_cycle();
        bus1.credit_in = 1'b0;
        drive1(1'b0, '0, 1'b0, 2'd0, 4'd0);
        check("sim3_cnt", 128'(bus1.credit_count), 128'd1);
        check_flit1("sim3", 128'hB3, 6'h02, 1'b1);
        next_cycle();
        check("sim_end_cnt", 128'(bus1.credit_count), 128'd0);
        bus1.credit_in = 1'b1;
        repeat (2) next_cycle();
        bus1.credit_in = 1'b0;
        check("sim_ret", 128'(bus1.credit_count), 128'd2);
        check("sim_err", 128'(bus1.err_credit_overflow), 128'd0);

        // Overflow while idle and full.
        bus1.credit_in = 1'b1;
        next_cycle();
        bus1.credit_in = 1'b0;
        check("ovf_cnt", 128'(bus1.credit_count), 128'd2);
        check("ovf_err", 128'(bus1.err_credit_overflow), 128'd1);
        repeat (10) next_cycle();
        check("ovf_sticky", 128'(bus1.err_credit_overflow), 128'd1);
        check("ovf_err4", 128'(bus4.err_credit_overflow), 128'd0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check("ovf_clr", 128'(bus1.err_credit_overflow), 128'd0);
        check("ovf_clr_cnt", 128'(bus1.credit_count), 128'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
